// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift-right-and-correct step per clock over 4*NDIG clocks; start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int NDIG  = 2,
  parameter int BIN_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BIN_W-1:0]  bin_out
);

  localparam int HW    = 4 * NDIG;
  localparam int SRW   = 2 * HW;
  localparam int CW    = $clog2(HW + 1);
  localparam int MIN_W = $clog2(10 ** NDIG);

  if (NDIG < 1 || NDIG > 4) begin : g_bad_ndig
    $error("bcd_to_bin_seq: NDIG must be in 1..4");
  end
  if (BIN_W < MIN_W) begin : g_bad_width
    $error("bcd_to_bin_seq: BIN_W too narrow for 10**NDIG-1");
  end

  typedef enum logic {IDLE, CONV} state_t;

  // A nibble that is >= 8 after the shift had its low bit pulled from the digit above
  // (worth 10 there, 8 here); subtracting 3 restores a valid decimal weight.
  function automatic logic [HW-1:0] correct_nibbles(input logic [HW-1:0] b);
    logic [HW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i+3]) r[4*i +: 4] = b[4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [HW-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [BIN_W-1:0] fit_bin(input logic [HW-1:0] b);
    logic [BIN_W+HW-1:0] ext;
    ext = {{BIN_W{1'b0}}, b};
    return ext[BIN_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [SRW-1:0]    sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [SRW-1:0]    shifted;

  // Next-state and datapath step
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    shifted = sr_q >> 1;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd_in)) begin
            done_d = 1'b1;
            err_d  = 1'b1;
            bin_d  = '0;
          end else begin
            sr_d    = {bcd_in, {HW{1'b0}}};
            cnt_d   = '0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        sr_d  = {correct_nibbles(shifted[SRW-1:HW]), shifted[HW-1:0]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HW - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          bin_d   = fit_bin(sr_d[HW-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (NDIG=2, BIN_W=7) with a queue scoreboard.
module tb_bcd_to_bin_seq;

  typedef struct packed {
    logic [6:0] bin;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bcd_in;
  logic       busy, done, err;
  logic [6:0] bin_out;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.NDIG(2), .BIN_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );

  function automatic exp_t model(input logic [7:0] b);
    exp_t e;
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) begin
      e.bin = 7'd0;
      e.err = 1'b1;
    end else begin
      e.bin = 7'(int'(b[7:4]) * 10 + int'(b[3:0]));
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Drives a one-cycle start; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [7:0] b);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    sb.push_back(model(b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = number of clock edges after the accepting edge at which done rose.
  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd_in = 8'h00;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (bin_out !== 7'd0) begin n_fail++; $display("FAIL reset_bin got %0d want 0", bin_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit seen; exp_t e;
    issue(8'h42);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(lat, seen);
    e = sb.pop_front();
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_timeout got no done want done"); end
    n_checks++; if (lat != 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b want 0", busy); end
    n_checks++; if (bin_out !== e.bin) begin n_fail++; $display("FAIL basic_bin got %0d want %0d", bin_out, e.bin); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL basic_err got %b want %b", err, e.err); end
    repeat (3) @(negedge clk);
    n_checks++; if (bin_out !== 7'd42) begin n_fail++; $display("FAIL basic_hold got %0d want 42", bin_out); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_boundaries();
    logic [7:0] vals [4];
    int lat; bit seen; exp_t e;
    vals = '{8'h00, 8'h09, 8'h10, 8'h99};
    for (int k = 0; k < 4; k++) begin
      issue(vals[k]);
      wait_done(lat, seen);
      e = sb.pop_front();
      n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL bound_latency %h got %0d want 8", vals[k], lat); end
      n_checks++; if (bin_out !== e.bin) begin n_fail++; $display("FAIL bound_bin %h got %0d want %0d", vals[k], bin_out, e.bin); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bound_err %h got %b want 0", vals[k], err); end
    end
  endtask

  task automatic test_invalid();
    int lat; bit seen; exp_t e;
    issue(8'h3A);
    e = sb.pop_front();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL inv_done got %b want 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL inv_busy got %b want 0", busy); end
    n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL inv_err got %b want %b", err, e.err); end
    n_checks++; if (bin_out !== e.bin) begin n_fail++; $display("FAIL inv_bin got %0d want %0d", bin_out, e.bin); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL inv_after got done=%b busy=%b want 0 0", done, busy); end
    issue(8'h57);
    wait_done(lat, seen);
    e = sb.pop_front();
    n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL inv_recover_latency got %0d want 8", lat); end
    n_checks++; if (bin_out !== e.bin || err !== e.err) begin n_fail++; $display("FAIL inv_recover got %0d/%b want %0d/%b", bin_out, err, e.bin, e.err); end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0; logic [6:0] got = 7'h7F; exp_t e;
    issue(8'h12);
    repeat (2) @(negedge clk);
    bcd_in = 8'h88; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin pulses++; got = bin_out; end
    end
    e = sb.pop_front();
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    n_checks++; if (got !== e.bin) begin n_fail++; $display("FAIL ignore_bin got %0d want %0d", got, e.bin); end
  endtask

  task automatic test_back_to_back();
    int t[3]; int pulses = 0; int extra = 0; exp_t e;
    e = model(8'h63);
    @(negedge clk);
    bcd_in = 8'h63; start = 1'b1;
    for (int i = 1; i < 60 && pulses < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t[pulses] = i;
        pulses++;
        n_checks++; if (bin_out !== e.bin || err !== e.err) begin n_fail++; $display("FAIL b2b_result got %0d/%b want %0d/%b", bin_out, err, e.bin, e.err); end
      end
    end
    start = 1'b0;
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", pulses); end
    // Accept happens on the edge that closes the done cycle, so the period is 4*NDIG+1.
    n_checks++; if (t[1] - t[0] != 9 || t[2] - t[1] != 9) begin n_fail++; $display("FAIL b2b_spacing got %0d,%0d want 9,9", t[1] - t[0], t[2] - t[1]); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL b2b_stop got %0d want 0", extra); end
  endtask

  task automatic test_reset_midflight();
    int extra = 0; int lat; bit seen; exp_t e;
    issue(8'h77);
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (bin_out !== 7'd0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_data got %0d/%b want 0/0", bin_out, err); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL rstmid_nodone got %0d want 0", extra); end
    issue(8'h25);
    wait_done(lat, seen);
    e = sb.pop_front();
    n_checks++; if (!seen || bin_out !== e.bin) begin n_fail++; $display("FAIL rstmid_after got %0d want %0d", bin_out, e.bin); end
  endtask

  task automatic test_exhaustive();
    int lat; bit seen; exp_t e; logic [7:0] b;
    for (int v = 0; v < 100; v++) begin
      b = {4'(v / 10), 4'(v % 10)};
      issue(b);
      wait_done(lat, seen);
      e = sb.pop_front();
      n_checks++; if (!seen || lat != 8) begin n_fail++; $display("FAIL exh_latency %h got %0d want 8", b, lat); end
      n_checks++; if (bin_out !== e.bin || err !== e.err) begin n_fail++; $display("FAIL exh_value %h got %0d/%b want %0d/%b", b, bin_out, err, e.bin, e.err); end
    end
  endtask

  task automatic test_midflight_change();
    bit seen; exp_t e; logic [7:0] b;
    for (int k = 0; k < 20; k++) begin
      b = {4'($urandom_range(9)), 4'($urandom_range(9))};
      issue(b);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        if (done === 1'b1) seen = 1'b1;
        else begin
          bcd_in = 8'($urandom);
          @(negedge clk);
        end
      end
      e = sb.pop_front();
      n_checks++; if (!seen || bin_out !== e.bin || err !== e.err) begin n_fail++; $display("FAIL midchange %h got %0d/%b want %0d/%b", b, bin_out, err, e.bin, e.err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_invalid();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midflight();
    test_exhaustive();
    test_midflight_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
